// File: rtl/tsu_ts_arbiter.sv
// tsu_ts_arbiter: round-robin reader of NUM_Q timestamp queues, forwarding one
// 128-bit record at a time on a valid/ready stream.  Rev 1.0
`default_nettype none

module tsu_ts_arbiter #(
  parameter int NUM_Q  = 4,
  parameter int RD_LAT = 1
) (
  input  logic                   q_rd_clk,
  input  logic                   rst,
  input  logic [NUM_Q-1:0]       q_en_mask,
  input  logic [8*NUM_Q-1:0]     q_rd_stat,
  input  logic [128*NUM_Q-1:0]   q_rd_data,
  output logic [NUM_Q-1:0]       q_rd_en,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [127:0]           m_tdata,
  output logic [2:0]             m_tid,
  output logic [15:0]            fwd_cnt
);

  localparam int         GW        = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;
  localparam logic [1:0] WAIT_LOAD = 2'(RD_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_grant_q, last_grant_d;
  logic [1:0]      wait_cnt_q, wait_cnt_d;
  logic [127:0]    tdata_q, tdata_d;
  logic [2:0]      tid_q, tid_d;
  logic [15:0]     fwd_cnt_q, fwd_cnt_d;

  logic [NUM_Q-1:0] req;
  logic [127:0]     q_word [NUM_Q];
  logic             rr_found;
  logic [GW-1:0]    rr_idx;
  logic [GW-1:0]    rr_cand;
  int               rr_pos;

  generate
    for (genvar gi = 0; gi < NUM_Q; gi++) begin : g_slice
      assign req[gi]    = q_en_mask[gi] & (|q_rd_stat[8*gi +: 4]);
      assign q_word[gi] = q_rd_data[128*gi +: 128];
    end
  endgenerate

  // Search starts one past the last serviced queue so every requester is
  // reached within NUM_Q grants.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_cand  = '0;
    rr_pos   = 0;
    for (int k = 1; k <= NUM_Q; k++) begin
      rr_pos  = (int'(last_grant_q) + k) % NUM_Q;
      rr_cand = GW'(rr_pos);
      if (!rr_found && req[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    wait_cnt_d   = wait_cnt_q;
    tdata_d      = tdata_q;
    tid_d        = tid_q;
    fwd_cnt_d    = fwd_cnt_q;
    q_rd_en      = '0;
    m_tvalid     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rr_found) begin
          grant_d = rr_idx;
          state_d = READ;
        end
      end
      READ: begin
        q_rd_en[grant_q] = 1'b1;
        last_grant_d     = grant_q;
        wait_cnt_d       = WAIT_LOAD;
        state_d          = WAIT;
      end
      WAIT: begin
        if (wait_cnt_q == 2'd0) begin
          tdata_d = q_word[grant_q];
          tid_d   = 3'(grant_q);
          state_d = HOLD;
        end else begin
          wait_cnt_d = wait_cnt_q - 2'd1;
        end
      end
      HOLD: begin
        m_tvalid = 1'b1;
        if (m_tready) begin
          fwd_cnt_d = fwd_cnt_q + 16'd1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge q_rd_clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_Q - 1);
      wait_cnt_q   <= 2'd0;
      tdata_q      <= '0;
      tid_q        <= 3'd0;
      fwd_cnt_q    <= 16'd0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
      tdata_q      <= tdata_d;
      tid_q        <= tid_d;
      fwd_cnt_q    <= fwd_cnt_d;
    end
  end

  assign m_tdata = tdata_q;
  assign m_tid   = tid_q;
  assign fwd_cnt = fwd_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_tsu_ts_arbiter.sv
// tb_tsu_ts_arbiter: directed and randomized checks of tsu_ts_arbiter against
// a queue model and a round-robin record-order reference.
`default_nettype none

module tb_tsu_ts_arbiter;

  localparam int NQ = 4;
  localparam int RL = 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NQ-1:0]      q_en_mask;
  logic [8*NQ-1:0]    q_rd_stat;
  logic [128*NQ-1:0]  q_rd_data;
  logic [NQ-1:0]      q_rd_en;
  logic               m_tvalid;
  logic               m_tready;
  logic [127:0]       m_tdata;
  logic [2:0]         m_tid;
  logic [15:0]        fwd_cnt;

  always #5 clk = ~clk;

  tsu_ts_arbiter #(.NUM_Q(NQ), .RD_LAT(RL)) dut (
    .q_rd_clk (clk),
    .rst      (rst),
    .q_en_mask(q_en_mask),
    .q_rd_stat(q_rd_stat),
    .q_rd_data(q_rd_data),
    .q_rd_en  (q_rd_en),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .m_tid    (m_tid),
    .fwd_cnt  (fwd_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Queue model: words appended by the stimulus, popped on each read strobe,
  // data presented one cycle after the strobe.
  logic [127:0] mem [NQ][32];
  int           wr_ptr [NQ] = '{default: 0};
  int           rd_ptr [NQ] = '{default: 0};
  logic [127:0] dout   [NQ] = '{default: '0};
  int           pulses   = 0;
  int           multihot = 0;

  always @(posedge clk) begin
    if (q_rd_en != '0) pulses <= pulses + 1;
    if ($countones(q_rd_en) > 1) multihot <= multihot + 1;
    for (int i = 0; i < NQ; i++) begin
      if (q_rd_en[i]) begin
        dout[i] <= mem[i][rd_ptr[i] % 32];
        if (rd_ptr[i] < wr_ptr[i]) rd_ptr[i] <= rd_ptr[i] + 1;
      end
    end
  end

  always_comb begin
    q_rd_stat = '0;
    q_rd_data = '0;
    for (int i = 0; i < NQ; i++) begin
      q_rd_stat[8*i +: 8]     = 8'(wr_ptr[i] - rd_ptr[i]);
      q_rd_data[128*i +: 128] = dout[i];
    end
  end

  // Reference: expected records in forwarding order.
  logic [2:0]   exp_tid  [$];
  logic [127:0] exp_data [$];
  int           exp_last   = NQ - 1;
  int           exp_pulses = 0;
  logic [15:0]  exp_fwd    = 16'd0;
  int           serial     = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int q, input int n);
    for (int k = 0; k < n; k++) begin
      serial++;
      mem[q][wr_ptr[q] % 32] = {8'(q), 24'(serial), $urandom, $urandom, $urandom};
      wr_ptr[q]++;
    end
  endtask

  task automatic build_expect();
    int cnt [NQ];
    int p   [NQ];
    int idx;
    bit found;
    for (int i = 0; i < NQ; i++) begin
      cnt[i] = wr_ptr[i] - rd_ptr[i];
      p[i]   = rd_ptr[i];
    end
    do begin
      found = 1'b0;
      for (int k = 1; k <= NQ; k++) begin
        idx = (exp_last + k) % NQ;
        if (!found && q_en_mask[idx] && cnt[idx] > 0) begin
          found = 1'b1;
          exp_tid.push_back(3'(idx));
          exp_data.push_back(mem[idx][p[idx] % 32]);
          cnt[idx]--;
          p[idx]++;
          exp_last = idx;
          exp_pulses++;
        end
      end
    end while (found);
  endtask

  task automatic drain(input int pct, input int budget);
    int           cyc = 0;
    bit           prev_hold = 1'b0;
    logic [127:0] pd = '0;
    logic [2:0]   pt = '0;
    while (exp_tid.size() > 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (prev_hold) begin
        chk("hold_valid", 128'(m_tvalid), 128'd1);
        chk("hold_data", m_tdata, pd);
        chk("hold_tid", 128'(m_tid), 128'(pt));
      end
      m_tready = ($urandom_range(99) < pct);
      if (m_tvalid && m_tready) begin
        chk("rec_tid", 128'(m_tid), 128'(exp_tid[0]));
        chk("rec_data", m_tdata, exp_data[0]);
        void'(exp_tid.pop_front());
        void'(exp_data.pop_front());
        exp_fwd++;
      end
      prev_hold = m_tvalid && !m_tready;
      pd = m_tdata;
      pt = m_tid;
    end
    chk("drain_left", 128'(exp_tid.size()), 128'd0);
    exp_tid.delete();
    exp_data.delete();
    @(negedge clk);
    m_tready = 1'b0;
    repeat (RL + 4) @(negedge clk);
    chk("idle_valid", 128'(m_tvalid), 128'd0);
    chk("read_pulses", 128'(pulses), 128'(exp_pulses));
    chk("fwd_cnt", 128'(fwd_cnt), 128'(exp_fwd));
    chk("onehot_rd_en", 128'(multihot), 128'd0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_rd_en"}, 128'(q_rd_en), 128'd0);
    chk({tag, "_valid"}, 128'(m_tvalid), 128'd0);
    chk({tag, "_tdata"}, m_tdata, 128'd0);
    chk({tag, "_tid"}, 128'(m_tid), 128'd0);
    chk({tag, "_fwd"}, 128'(fwd_cnt), 128'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    reset_checks("rst");
    @(negedge clk);
    rst = 1'b0;
    exp_last = NQ - 1;
    exp_fwd  = 16'd0;
  endtask

  initial begin
    logic [127:0] sd;
    logic [2:0]   st;
    int           sp;
    int           w;

    m_tready  = 1'b0;
    q_en_mask = '1;
    repeat (2) @(negedge clk);
    reset_checks("por");
    rst = 1'b0;
    @(negedge clk);

    // Single record from queue 0: strobe, latency and handshake.
    m_tready = 1'b1;
    load(0, 1);
    build_expect();
    @(negedge clk);
    chk("first_rd_en", 128'(q_rd_en), 128'd1);
    chk("first_valid_early", 128'(m_tvalid), 128'd0);
    repeat (RL) begin
      @(negedge clk);
      chk("first_rd_en_off", 128'(q_rd_en), 128'd0);
      chk("first_valid_wait", 128'(m_tvalid), 128'd0);
    end
    @(negedge clk);
    chk("first_valid", 128'(m_tvalid), 128'd1);
    chk("first_tid", 128'(m_tid), 128'(exp_tid[0]));
    chk("first_tdata", m_tdata, exp_data[0]);
    void'(exp_tid.pop_front());
    void'(exp_data.pop_front());
    exp_fwd++;
    @(negedge clk);
    m_tready = 1'b0;
    chk("first_valid_drop", 128'(m_tvalid), 128'd0);
    chk("first_fwd", 128'(fwd_cnt), 128'(exp_fwd));

    // All queues with two words: 0,1,2,3,0,1,2,3 after reset.
    do_reset();
    for (int i = 0; i < NQ; i++) load(i, 2);
    build_expect();
    drain(100, 200);

    // Downstream stall in HOLD with another queue still requesting.
    load(0, 1);
    load(1, 1);
    build_expect();
    w = 0;
    while (!m_tvalid && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("stall_valid_seen", 128'(m_tvalid), 128'd1);
    sd = m_tdata;
    st = m_tid;
    sp = pulses;
    repeat (10) begin
      @(negedge clk);
      chk("stall_valid", 128'(m_tvalid), 128'd1);
      chk("stall_data", m_tdata, sd);
      chk("stall_tid", 128'(m_tid), 128'(st));
      chk("stall_rd_en", 128'(q_rd_en), 128'd0);
    end
    chk("stall_pulses", 128'(pulses), 128'(sp));
    drain(100, 100);

    // Mask 0101: only queues 0 and 2 serviced, then the rest once unmasked.
    q_en_mask = 4'b0101;
    for (int i = 0; i < NQ; i++) load(i, 2);
    build_expect();
    drain(70, 200);
    q_en_mask = 4'b1111;
    build_expect();
    drain(70, 200);

    // Reset while the read of queue 2 is in WAIT.
    load(2, 1);
    @(negedge clk);
    chk("abort_read_en", 128'(q_rd_en), 128'd4);
    @(negedge clk);
    chk("abort_wait_valid", 128'(m_tvalid), 128'd0);
    exp_pulses++;
    rst = 1'b1;
    @(negedge clk);
    reset_checks("midwait");
    @(negedge clk);
    rst = 1'b0;
    exp_last = NQ - 1;
    exp_fwd  = 16'd0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_rd_en", 128'(q_rd_en), 128'd0);
      chk("post_rst_valid", 128'(m_tvalid), 128'd0);
      chk("post_rst_fwd", 128'(fwd_cnt), 128'd0);
    end
    for (int i = 0; i < NQ; i++) load(i, 1);
    build_expect();
    drain(100, 100);

    // Counter wrap from 0xFFFF.
    force dut.fwd_cnt_q = 16'hFFFF;
    repeat (2) @(negedge clk);
    release dut.fwd_cnt_q;
    exp_fwd = 16'hFFFF;
    @(negedge clk);
    chk("preset_fwd", 128'(fwd_cnt), 128'(exp_fwd));
    load(3, 1);
    build_expect();
    drain(100, 50);
    chk("wrap_fwd", 128'(fwd_cnt), 128'd0);

    // Randomized rounds.
    for (int r = 0; r < 8; r++) begin
      q_en_mask = NQ'($urandom_range(15));
      for (int i = 0; i < NQ; i++) begin
        if (wr_ptr[i] - rd_ptr[i] <= 6) load(i, $urandom_range(2));
      end
      build_expect();
      drain(50, 400);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
